// File: rtl/fpu_add_input_gen.sv
// Purpose : free-running request generator for the FPU add/compare pipe.
//           It needs no inputs other than clk/rst.
// Latency : the first strobe follows the GAP-th rising edge after reset
//           release. Later strobes follow every GAP edges.
// Backpr. : none. The adder is assumed always ready, and the payload holds
//           between strobes.
// Ports   : clk, rst (async, active-low) ; opcode/round_mode/req_id/req_cc_id
//           request fields ; operand1/2 with their pre-decode flags ;
//           add_req one-cycle strobe.
module fpu_add_input_gen #(
  parameter logic [63:0] SEED    = 64'h0123_4567_89AB_CDEF,
  parameter int          GAP     = 4,
  parameter int          NUM_REQ = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  opcode,
  output logic [1:0]  round_mode,
  output logic [4:0]  req_id,
  output logic [1:0]  req_cc_id,
  output logic [63:0] operand1,
  output logic        oprd1_50_0_neq_0,
  output logic        oprd1_53_32_neq_0,
  output logic        oprd1_exp_neq_0,
  output logic        oprd1_exp_neq_ff,
  output logic [63:0] operand2,
  output logic        oprd2_50_0_neq_0,
  output logic        oprd2_53_32_neq_0,
  output logic        oprd2_exp_neq_0,
  output logic        oprd2_exp_neq_ff,
  output logic        add_req
);

  localparam logic [7:0]  GAP_M1  = 8'(GAP - 1);
  localparam logic [31:0] REQ_MAX = 32'(NUM_REQ);

  logic [7:0]  gap_cnt;
  logic [31:0] req_count;
  logic [31:0] issued;
  logic [63:0] lfsr_a;
  logic [63:0] lfsr_b;

  // Only k[6:0] reaches an output. The rest of the counter has no consumer.
  logic req_count_unused;
  assign req_count_unused = ^req_count[31:7];

  function automatic logic [7:0] op_lut(input logic [2:0] k);
    logic [7:0] op;
    op = 8'h41;
    case (k)
      3'd0: op = 8'h41;  // FADDs
      3'd1: op = 8'h42;  // FADDd
      3'd2: op = 8'h45;  // FSUBs
      3'd3: op = 8'h46;  // FSUBd
      3'd4: op = 8'h51;  // FCMPs
      3'd5: op = 8'h52;  // FCMPd
      3'd6: op = 8'h55;  // FCMPEs
      3'd7: op = 8'h56;  // FCMPEd
      default: op = 8'h41;
    endcase
    return op;
  endfunction

  // Fibonacci step with taps 64,63,61,60. The shift-left form keeps a zero
  // state unreachable from any nonzero seed.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Flag order: {50_0, 53_32, exp_neq_0, exp_neq_ff}.
  // A single-precision value lives in the upper word, so its 8-bit exponent
  // is [62:55]. A double's 11-bit exponent is [62:52].
  function automatic logic [3:0] calc_flags(input logic [63:0] op,
                                            input logic        sgl);
    logic ez;
    logic ef;
    if (sgl) begin
      ez = (op[62:55] != 8'h00);
      ef = (op[62:55] != 8'hFF);
    end else begin
      ez = (op[62:52] != 11'h000);
      ef = (op[62:52] != 11'h7FF);
    end
    return {|op[50:0], |op[53:32], ez, ef};
  endfunction

  logic        enabled;
  logic        issue;
  logic [7:0]  nxt_opcode;
  logic        nxt_sgl;
  logic [63:0] nxt_op1;
  logic [63:0] nxt_op2;
  logic [3:0]  nxt_f1;
  logic [3:0]  nxt_f2;

  always_comb begin
    enabled    = (NUM_REQ == 0) || (issued < REQ_MAX);
    issue      = (gap_cnt == GAP_M1) && enabled;
    nxt_opcode = op_lut(req_count[2:0]);
    nxt_sgl    = nxt_opcode[0];
    nxt_op1    = nxt_sgl ? {lfsr_a[63:32], 32'h0} : lfsr_a;
    nxt_op2    = nxt_sgl ? {lfsr_b[63:32], 32'h0} : lfsr_b;
    nxt_f1     = calc_flags(nxt_op1, nxt_sgl);
    nxt_f2     = calc_flags(nxt_op2, nxt_sgl);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt           <= '0;
      req_count         <= '0;
      issued            <= '0;
      lfsr_a            <= SEED;
      lfsr_b            <= ~SEED;
      add_req           <= 1'b0;
      opcode            <= '0;
      round_mode        <= '0;
      req_id            <= '0;
      req_cc_id         <= '0;
      operand1          <= '0;
      operand2          <= '0;
      oprd1_50_0_neq_0  <= 1'b0;
      oprd1_53_32_neq_0 <= 1'b0;
      oprd1_exp_neq_0   <= 1'b0;
      oprd1_exp_neq_ff  <= 1'b0;
      oprd2_50_0_neq_0  <= 1'b0;
      oprd2_53_32_neq_0 <= 1'b0;
      oprd2_exp_neq_0   <= 1'b0;
      oprd2_exp_neq_ff  <= 1'b0;
    end else begin
      // The gap counter keeps cycling after NUM_REQ is reached. It is just
      // never allowed to fire again.
      gap_cnt <= (gap_cnt == GAP_M1) ? 8'h00 : gap_cnt + 8'h01;
      add_req <= issue;
      if (issue) begin
        req_count  <= req_count + 32'd1;
        if (issued != 32'hFFFF_FFFF) issued <= issued + 32'd1;
        lfsr_a     <= lfsr_step(lfsr_a);
        lfsr_b     <= lfsr_step(lfsr_b);
        opcode     <= nxt_opcode;
        round_mode <= req_count[6:5];
        req_id     <= req_count[4:0];
        req_cc_id  <= req_count[1:0];
        operand1   <= nxt_op1;
        operand2   <= nxt_op2;
        {oprd1_50_0_neq_0, oprd1_53_32_neq_0, oprd1_exp_neq_0, oprd1_exp_neq_ff} <= nxt_f1;
        {oprd2_50_0_neq_0, oprd2_53_32_neq_0, oprd2_exp_neq_0, oprd2_exp_neq_ff} <= nxt_f2;
      end
    end
  end

endmodule

// File: tb/tb_fpu_add_input_gen.sv
// Purpose : scoreboard bench for fpu_add_input_gen. Three instances share
//           one clock and reset: a main stream, a double-precision flag
//           corner, and a single-precision corner with NUM_REQ=3.
// Checks  : expected requests are queued at reset release. A negedge monitor
//           pops one entry per strobe, compares it, and checks strobe spacing.
module tb_fpu_add_input_gen;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [1:0]  rm;
    logic [4:0]  id;
    logic [1:0]  cc;
    logic [63:0] op1;
    logic [3:0]  f1;   // {50_0, 53_32, exp_neq_0, exp_neq_ff}
    logic [63:0] op2;
    logic [3:0]  f2;
  } req_t;

  localparam int GAP = 4;
  localparam logic [63:0] SEED_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED_B = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] SEED_C = 64'h0000_0001_0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  opcode     [3];
  logic [1:0]  round_mode [3];
  logic [4:0]  req_id     [3];
  logic [1:0]  req_cc_id  [3];
  logic [63:0] operand1   [3];
  logic [63:0] operand2   [3];
  logic        f1a [3];
  logic        f1b [3];
  logic        f1c [3];
  logic        f1d [3];
  logic        f2a [3];
  logic        f2b [3];
  logic        f2c [3];
  logic        f2d [3];
  logic        add_req    [3];

  fpu_add_input_gen #(.SEED(SEED_A), .GAP(GAP), .NUM_REQ(0)) u_a (
    .clk(clk), .rst(rst), .opcode(opcode[0]), .round_mode(round_mode[0]),
    .req_id(req_id[0]), .req_cc_id(req_cc_id[0]), .operand1(operand1[0]),
    .oprd1_50_0_neq_0(f1a[0]), .oprd1_53_32_neq_0(f1b[0]),
    .oprd1_exp_neq_0(f1c[0]), .oprd1_exp_neq_ff(f1d[0]),
    .operand2(operand2[0]),
    .oprd2_50_0_neq_0(f2a[0]), .oprd2_53_32_neq_0(f2b[0]),
    .oprd2_exp_neq_0(f2c[0]), .oprd2_exp_neq_ff(f2d[0]),
    .add_req(add_req[0]));

  fpu_add_input_gen #(.SEED(SEED_B), .GAP(GAP), .NUM_REQ(2)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode[1]), .round_mode(round_mode[1]),
    .req_id(req_id[1]), .req_cc_id(req_cc_id[1]), .operand1(operand1[1]),
    .oprd1_50_0_neq_0(f1a[1]), .oprd1_53_32_neq_0(f1b[1]),
    .oprd1_exp_neq_0(f1c[1]), .oprd1_exp_neq_ff(f1d[1]),
    .operand2(operand2[1]),
    .oprd2_50_0_neq_0(f2a[1]), .oprd2_53_32_neq_0(f2b[1]),
    .oprd2_exp_neq_0(f2c[1]), .oprd2_exp_neq_ff(f2d[1]),
    .add_req(add_req[1]));

  fpu_add_input_gen #(.SEED(SEED_C), .GAP(GAP), .NUM_REQ(3)) u_c (
    .clk(clk), .rst(rst), .opcode(opcode[2]), .round_mode(round_mode[2]),
    .req_id(req_id[2]), .req_cc_id(req_cc_id[2]), .operand1(operand1[2]),
    .oprd1_50_0_neq_0(f1a[2]), .oprd1_53_32_neq_0(f1b[2]),
    .oprd1_exp_neq_0(f1c[2]), .oprd1_exp_neq_ff(f1d[2]),
    .operand2(operand2[2]),
    .oprd2_50_0_neq_0(f2a[2]), .oprd2_53_32_neq_0(f2b[2]),
    .oprd2_exp_neq_0(f2c[2]), .oprd2_exp_neq_ff(f2d[2]),
    .add_req(add_req[2]));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cnt  [3];
  int last [3];
  req_t q0[$];
  req_t q1[$];
  req_t q2[$];
  req_t c_third;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] lstep(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  function automatic logic [3:0] mflags(input logic [63:0] op, input logic sgl);
    logic [10:0] e;
    logic [10:0] ones;
    if (sgl) begin
      e = {3'b0, op[62:55]};
      ones = 11'h0FF;
    end else begin
      e = op[62:52];
      ones = 11'h7FF;
    end
    return {op[50:0] != 51'd0, op[53:32] != 22'd0, e != 11'd0, e != ones};
  endfunction

  function automatic req_t model(input int k, input logic [63:0] la, input logic [63:0] lb);
    req_t r;
    logic [7:0] tbl [8];
    logic [31:0] kk;
    tbl = '{8'h41, 8'h42, 8'h45, 8'h46, 8'h51, 8'h52, 8'h55, 8'h56};
    kk = 32'(k);
    r.opcode = tbl[kk[2:0]];
    r.rm  = kk[6:5];
    r.id  = kk[4:0];
    r.cc  = kk[1:0];
    r.op1 = r.opcode[0] ? {la[63:32], 32'h0} : la;
    r.op2 = r.opcode[0] ? {lb[63:32], 32'h0} : lb;
    r.f1  = mflags(r.op1, r.opcode[0]);
    r.f2  = mflags(r.op2, r.opcode[0]);
    return r;
  endfunction

  function automatic req_t grab(input int i);
    req_t r;
    r.opcode = opcode[i];
    r.rm  = round_mode[i];
    r.id  = req_id[i];
    r.cc  = req_cc_id[i];
    r.op1 = operand1[i];
    r.f1  = {f1a[i], f1b[i], f1c[i], f1d[i]};
    r.op2 = operand2[i];
    r.f2  = {f2a[i], f2b[i], f2c[i], f2d[i]};
    return r;
  endfunction

  // Rebuild all three expectation queues from the seeds. Call this while rst is low.
  task automatic arm();
    logic [63:0] la;
    logic [63:0] lb;
    q0.delete(); q1.delete(); q2.delete();
    la = SEED_A; lb = ~SEED_A;
    for (int k = 0; k < 48; k++) begin
      q0.push_back(model(k, la, lb));
      la = lstep(la); lb = lstep(lb);
    end
    la = SEED_B; lb = ~SEED_B;
    for (int k = 0; k < 2; k++) begin
      q1.push_back(model(k, la, lb));
      la = lstep(la); lb = lstep(lb);
    end
    la = SEED_C; lb = ~SEED_C;
    for (int k = 0; k < 3; k++) begin
      c_third = model(k, la, lb);
      q2.push_back(c_third);
      la = lstep(la); lb = lstep(lb);
    end
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      last[i] = -1;
    end
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < 3; i++)
      chk(nm, 160'({add_req[i], grab(i)}), 160'd0);
  endtask

  task automatic wait_cnt(input int i, input int n, input string nm);
    for (int c = 0; c < 400 && cnt[i] < n; c++) @(posedge clk);
    @(negedge clk);
    chk(nm, 160'(cnt[i] >= n), 160'd1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && add_req[i]) begin
        req_t act;
        req_t exp;
        logic got;
        act = grab(i);
        got = 1'b0;
        exp = '0;
        case (i)
          0: if (q0.size() > 0) begin exp = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin exp = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin exp = q2.pop_front(); got = 1'b1; end
        endcase
        chk($sformatf("strobe_expected[%0d]", i), 160'(got), 160'd1);
        if (got) chk($sformatf("payload[%0d] #%0d", i, cnt[i]), 160'(act), 160'(exp));
        if (last[i] >= 0)
          chk($sformatf("spacing[%0d]", i), 160'(cyc - last[i]), 160'(GAP));
        // Hand-computed corners
        if (i == 0 && cnt[i] == 0) begin
          chk("a0_opcode", 160'(act.opcode), 160'(8'h41));
          chk("a0_op1", 160'(act.op1), 160'(64'h0123_4567_0000_0000));
          chk("a0_op2", 160'(act.op2), 160'(64'hFEDC_BA98_0000_0000));
          chk("a0_fields", 160'({act.rm, act.id, act.cc}), 160'd0);
        end
        if (i == 0 && cnt[i] == 1)
          chk("a1_fields", 160'({act.opcode, act.id, act.cc}), 160'({8'h42, 5'd1, 2'd1}));
        if (i == 0 && cnt[i] == 32)
          chk("a32_rm_wrap", 160'({act.rm, act.id}), 160'({2'd1, 5'd0}));
        if (i == 1 && cnt[i] == 1)
          chk("b1_dbl_corner", 160'({act.op1, act.f1}), 160'({64'h7FF0_0000_0000_0000, 4'b0110}));
        if (i == 2 && cnt[i] == 0)
          chk("c0_sgl_corner", 160'({act.op1, act.f1, act.op2, act.f2}),
              160'({64'h0000_0001_0000_0000, 4'b1101, 64'hFFFF_FFFE_0000_0000, 4'b1110}));
        cnt[i]  = cnt[i] + 1;
        last[i] = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; last[i] = -1; end
    #1 rst = 1'b0;
    arm();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    #1 rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      check_zero($sformatf("idle_edge%0d", e));
    end

    // 40 requests on the main stream. B and C finish long before that.
    wait_cnt(0, 40, "a_40_strobes");
    chk("b_count", 160'(cnt[1]), 160'd2);
    chk("c_count", 160'(cnt[2]), 160'd3);
    chk("c_hold", 160'({add_req[2], grab(2)}), 160'({1'b0, c_third}));

    // Reset after the run: the restart must replay the identical sequence.
    #2 rst = 1'b0;
    #1 check_zero("async_reset_1");
    arm();
    @(negedge clk);
    #1 rst = 1'b1;
    wait_cnt(0, 5, "a_5_strobes");
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;  // mid-gap
    #1 check_zero("async_reset_mid_gap");
    arm();
    @(negedge clk);
    #1 rst = 1'b1;
    wait_cnt(0, 3, "a_restart_strobes");
    chk("b_count_restart", 160'(cnt[1]), 160'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
